// File: rtl/bram_stream_reader_pkg.sv
// Shared FSM encodings and default geometry for the BRAM stream blocks.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH     = 72;
  localparam int DEF_LOG_DEPTH = 9;
  localparam int DEF_DEPTH     = 2 ** DEF_LOG_DEPTH;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register FIFO feeding a ready/valid stream; write-to-valid latency 1 cycle.
// Occupancy is exported so the producer can throttle before it could overflow.
module stream_skid_buf #(
  parameter int WIDTH = 73
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem0, mem1;
  logic             rd_ptr, wr_ptr;
  logic [1:0]       cnt;
  logic             pop;

  assign pop    = rd_vld && rd_rdy;
  assign rd_vld = (cnt != 2'd0);
  assign rd_dat = rd_ptr ? mem1 : mem0;
  assign occ    = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr_vld) begin
        if (wr_ptr) mem1 <= wr_dat;
        else        mem0 <= wr_dat;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, wr_vld} - {1'b0, pop};
      assert (!(wr_vld && !pop && cnt == 2'd2));
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Streams cmd_len words from BRAM starting at cmd_addr; first beat 3 cycles after the command handshake.
// Reads are throttled so issued-but-unconsumed words never exceed the 2-entry output buffer.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LOG_DEPTH-1:0] cmd_addr,
  input  logic [LOG_DEPTH:0]   cmd_len,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [LOG_DEPTH-1:0] bram_addr,
  output logic                 bram_en,
  input  logic [WIDTH-1:0]     bram_rdata,
  output logic [WIDTH-1:0]     ms_data,
  output logic                 ms_valid,
  input  logic                 ms_ready,
  output logic                 ms_last,
  output logic                 done
);

  localparam logic [LOG_DEPTH:0]   MAX_LEN  = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   LEN_ONE  = {{LOG_DEPTH{1'b0}}, 1'b1};
  localparam logic [LOG_DEPTH-1:0] ADDR_ONE = {{(LOG_DEPTH-1){1'b0}}, 1'b1};

  state_t             state;
  logic [LOG_DEPTH:0] issue_rem, emit_rem;
  logic               inflight, inflight_last;
  logic [1:0]         occ;
  logic               pop;
  logic [2:0]         level;
  logic [WIDTH:0]     head;

  assign pop       = ms_valid && ms_ready;
  assign level     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign bram_en   = (state == ST_ISSUE) && (level < 3'd2);
  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign ms_data   = head[WIDTH-1:0];
  assign ms_last   = ms_valid && head[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      bram_addr     <= '0;
      issue_rem     <= '0;
      emit_rem      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= bram_en;
      inflight_last <= bram_en && (issue_rem == LEN_ONE);
      done          <= 1'b0;
      if (pop) emit_rem <= emit_rem - LEN_ONE;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          assert (cmd_len <= MAX_LEN);
          bram_addr <= cmd_addr;
          issue_rem <= cmd_len;
          emit_rem  <= cmd_len;
          if (cmd_len == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: if (bram_en) begin
          bram_addr <= bram_addr + ADDR_ONE;
          issue_rem <= issue_rem - LEN_ONE;
          if (issue_rem == LEN_ONE) state <= ST_DRAIN;
        end
        // Jump straight to DONE on the last handshake so done lands one cycle after it.
        ST_DRAIN: if (pop && emit_rem == LEN_ONE) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  stream_skid_buf #(.WIDTH(WIDTH + 1)) u_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (inflight),
    .wr_dat ({inflight_last, bram_rdata}),
    .rd_vld (ms_valid),
    .rd_rdy (ms_ready),
    .rd_dat (head),
    .occ    (occ)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader against a 1-cycle-latency BRAM preloaded with mem[i]=i.
module tb_bram_stream_reader;
  localparam int WIDTH = 72, DEPTH = 512, LOG_DEPTH = 9;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [LOG_DEPTH-1:0] cmd_addr = '0;
  logic [LOG_DEPTH:0]   cmd_len = '0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [LOG_DEPTH-1:0] bram_addr;
  logic                 bram_en;
  logic [WIDTH-1:0]     bram_rdata;
  logic [WIDTH-1:0]     ms_data;
  logic                 ms_valid;
  logic                 ms_ready = 1'b1;
  logic                 ms_last;
  logic                 done;

  bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_rdata(bram_rdata),
    .ms_data(ms_data), .ms_valid(ms_valid), .ms_ready(ms_ready), .ms_last(ms_last),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) if (bram_en) bram_rdata <= mem[bram_addr];

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH:0] exp_q [$];
  int beats = 0, done_cnt = 0, done_cyc = -1, last_pop_cyc = -1, first_valid_cyc = -1;
  int occ_cnt = 0;
  logic held_v = 1'b0;
  logic [WIDTH:0] held;

  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (reset) begin
      occ_cnt = 0;
      held_v  = 1'b0;
    end else begin
      if (held_v) begin
        checks++;
        if (ms_valid !== 1'b1 || {ms_last, ms_data} !== held) begin
          failures++;
          $display("FAIL stall_stable got v=%b %h exp v=1 %h", ms_valid, {ms_last, ms_data}, held);
        end
      end
      held_v = ms_valid && !ms_ready;
      held   = {ms_last, ms_data};
      if (ms_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (ms_valid === 1'b1 && ms_ready === 1'b1) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat got=%h exp=no beat", {ms_last, ms_data});
        end else begin
          e = exp_q.pop_front();
          if ({ms_last, ms_data} !== e) begin
            failures++;
            $display("FAIL beat got last=%b data=%h exp last=%b data=%h", ms_last, ms_data, e[WIDTH], e[WIDTH-1:0]);
          end
        end
        if (ms_last === 1'b1) last_pop_cyc = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      occ_cnt = occ_cnt + int'(bram_en) - int'(ms_valid && ms_ready);
      checks++;
      if (occ_cnt > 2) begin
        failures++;
        $display("FAIL occupancy got=%0d exp<=2", occ_cnt);
      end
    end
  end

  task automatic send_cmd(input int addr, input int len, input int budget, output int hs);
    int n;
    @(posedge clk); #1;
    cmd_addr  = LOG_DEPTH'(addr);
    cmd_len   = (LOG_DEPTH+1)'(len);
    cmd_valid = 1'b1;
    hs = -1;
    n  = 0;
    while (hs < 0 && n < budget) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        hs = cyc;
        for (int i = 0; i < len; i++)
          exp_q.push_back({(i == len - 1), WIDTH'((addr + i) % DEPTH)});
      end
      n++;
    end
    checks++;
    if (hs < 0) begin
      failures++;
      $display("FAIL cmd_accept got=none exp=handshake within %0d cycles", budget);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL done_count got=%0d exp=%0d", done_cnt - d0, 1);
    end
  endtask

  task automatic check_stream_end(input string name, input int b0, input int nbeats);
    checks++;
    if (beats - b0 != nbeats) begin
      failures++;
      $display("FAIL %s_beats got=%0d exp=%0d", name, beats - b0, nbeats);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing got=%0d left exp=0", name, exp_q.size());
    end
    checks++;
    if (done_cyc != last_pop_cyc + 1) begin
      failures++;
      $display("FAIL %s_done_timing got=%0d exp=%0d", name, done_cyc, last_pop_cyc + 1);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || ms_valid !== 1'b0 || bram_en !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b v=%b en=%b done=%b exp 0 0 0 0", cmd_ready, ms_valid, bram_en, done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || bram_addr !== '0 || ms_last !== 1'b0 || ms_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got rdy=%b addr=%h last=%b v=%b exp 1 0 0 0", cmd_ready, bram_addr, ms_last, ms_valid);
    end
  endtask

  task automatic test_basic();
    int hs, d0, b0;
    d0 = done_cnt; b0 = beats; first_valid_cyc = -1;
    send_cmd(32'h010, 4, 20, hs);
    wait_done(d0, 100);
    check_stream_end("basic", b0, 4);
    checks++;
    if (first_valid_cyc != hs + 3) begin
      failures++;
      $display("FAIL first_valid_latency got=%0d exp=%0d", first_valid_cyc - hs, 3);
    end
  endtask

  task automatic test_wrap();
    int hs, d0, b0;
    d0 = done_cnt; b0 = beats;
    send_cmd(32'h1FE, 4, 20, hs);
    wait_done(d0, 100);
    check_stream_end("wrap", b0, 4);
  endtask

  task automatic test_backpressure();
    int hs, d0, b0, n;
    d0 = done_cnt; b0 = beats;
    send_cmd(32'h030, 64, 20, hs);
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(posedge clk); #1;
      ms_ready = 1'($urandom_range(0, 1));
      n++;
    end
    ms_ready = 1'b1;
    wait_done(d0, 10);
    check_stream_end("bp", b0, 64);
  endtask

  task automatic test_zero_len();
    int hs, d0, b0;
    d0 = done_cnt; b0 = beats; first_valid_cyc = -1;
    send_cmd(32'h020, 0, 20, hs);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got done=%b rdy=%b exp done=1 rdy=0", done, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_idle got done=%b rdy=%b exp done=0 rdy=1", done, cmd_ready);
    end
    checks++;
    if (beats != b0 || first_valid_cyc != -1 || done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL zero_no_beats got beats=%0d valid_cyc=%0d dones=%0d exp 0 -1 1", beats - b0, first_valid_cyc, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int hs1, hs2, d0, b0;
    d0 = done_cnt; b0 = beats; first_valid_cyc = -1;
    send_cmd(32'h100, 512, 20, hs1);
    send_cmd(32'h005, 1, 700, hs2);
    checks++;
    if (hs2 != done_cyc + 1 || done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL second_cmd_accept got=%0d exp=%0d", hs2, done_cyc + 1);
    end
    checks++;
    if (last_pop_cyc - first_valid_cyc != 511 || beats - b0 != 512) begin
      failures++;
      $display("FAIL full_throughput got span=%0d beats=%0d exp span=511 beats=512", last_pop_cyc - first_valid_cyc, beats - b0);
    end
    wait_done(d0 + 1, 100);
    check_stream_end("second", b0 + 512, 1);
  endtask

  task automatic test_reset_mid();
    int hs, d0, b0, n;
    d0 = done_cnt; b0 = beats;
    send_cmd(32'h040, 20, 20, hs);
    n = 0;
    while (beats - b0 < 5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    reset    = 1'b1;
    ms_ready = 1'b0;
    @(posedge clk); #1;
    reset    = 1'b0;
    ms_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (ms_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_state got v=%b rdy=%b exp v=0 rdy=1", ms_valid, cmd_ready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != d0 || beats - b0 != 5) begin
      failures++;
      $display("FAIL abort_quiet got dones=%0d beats=%0d exp dones=0 beats=5", done_cnt - d0, beats - b0);
    end
    d0 = done_cnt; b0 = beats;
    send_cmd(32'h080, 2, 20, hs);
    wait_done(d0, 100);
    check_stream_end("after_abort", b0, 2);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
